// File: rtl/vga_pkg.sv
// Shared VGA timing definitions for the receiver and the transmitter controllers.
package vga_pkg;

  localparam int unsigned H_ACTIVO_DEF = 640;
  localparam int unsigned V_ACTIVO_DEF = 480;
  localparam int unsigned COL_W        = 10;
  localparam int unsigned LINEA_W      = 9;
  localparam int unsigned PIXEL_W      = 24;

  typedef enum logic [1:0] {
    BUSCAR,
    ESPERA,
    ACTIVO
  } estado_t;

endpackage

// File: rtl/detector_flanco.sv
// One-bit input register plus rising/falling edge detection against the previous sample.
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic subida,
  output logic bajada
);

  logic q_ant;

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= 1'b0;
      q_ant <= 1'b0;
    end else begin
      q     <= d;
      q_ant <= q;
    end
  end

  assign subida = q & ~q_ant;
  assign bajada = ~q & q_ant;

endmodule

// File: rtl/receptor_vga.sv
// VGA capture: registers the incoming timing, tracks column/line and checks frame geometry.
module receptor_vga
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVO = H_ACTIVO_DEF,
  parameter int unsigned V_ACTIVO = V_ACTIVO_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               n_blank,
  input  logic [PIXEL_W-1:0] pixel_in,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic [COL_W-1:0]   pixel_x,
  output logic [LINEA_W-1:0] linea_num,
  output logic               pixel_valid,
  output logic               frame_start,
  output logic               locked,
  output logic               error
);

  // Counters saturate one past the limit so an over-long run is still distinguishable.
  localparam logic [COL_W-1:0]   H_LIM = COL_W'(H_ACTIVO);
  localparam logic [COL_W-1:0]   H_SAT = COL_W'(H_ACTIVO + 1);
  localparam logic [LINEA_W-1:0] V_LIM = LINEA_W'(V_ACTIVO);
  localparam logic [LINEA_W-1:0] V_SAT = LINEA_W'(V_ACTIVO + 1);

  logic               hs_q;
  logic [PIXEL_W-1:0] pix_q;
  logic               vs_q, vs_sube, vs_baja;
  logic               nb_q, nb_sube, nb_baja;

  estado_t            estado, estado_n;
  logic [COL_W-1:0]   col, col_n, col_ef;
  logic [LINEA_W-1:0] linea, linea_n;
  logic               locked_n, error_n, valid_n, en_activo, violacion;

  detector_flanco u_vsync (
    .clk    (clk),
    .rst    (rst),
    .d      (vsync),
    .q      (vs_q),
    .subida (vs_sube),
    .bajada (vs_baja)
  );

  detector_flanco u_nblank (
    .clk    (clk),
    .rst    (rst),
    .d      (n_blank),
    .q      (nb_q),
    .subida (nb_sube),
    .bajada (nb_baja)
  );

  assign violacion = ~nb_q & (vs_q | hs_q);

  always_comb begin
    estado_n  = estado;
    col_n     = col;
    linea_n   = linea;
    locked_n  = locked;
    error_n   = 1'b0;
    valid_n   = 1'b0;
    col_ef    = nb_baja ? '0 : col;
    en_activo = (estado == ACTIVO) || ((estado == ESPERA) && nb_baja);

    if (!nb_q) begin
      if ((estado == ESPERA) && nb_baja) estado_n = ACTIVO;
      valid_n = en_activo && (col_ef < H_LIM) && (linea < V_LIM);
      col_n   = (col_ef < H_SAT) ? col_ef + 1'b1 : col_ef;
    end

    if (nb_sube && (estado == ACTIVO)) begin
      if (col != H_LIM) begin
        error_n  = 1'b1;
        locked_n = 1'b0;
        estado_n = BUSCAR;
      end else if (linea < V_SAT) begin
        linea_n = linea + 1'b1;
      end
    end

    if (vs_sube) begin
      if (estado == ACTIVO) begin
        if ((linea_n == V_LIM) && !error_n) locked_n = 1'b1;
        else begin
          error_n  = 1'b1;
          locked_n = 1'b0;
        end
      end
      estado_n = ESPERA;
      linea_n  = '0;
    end

    // Overlapping sync and active video overrides every other decision this cycle.
    if (violacion) begin
      error_n  = 1'b1;
      locked_n = 1'b0;
      estado_n = BUSCAR;
      valid_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q        <= 1'b0;
      pix_q       <= '0;
      estado      <= BUSCAR;
      col         <= '0;
      linea       <= '0;
      pixel_out   <= '0;
      pixel_x     <= '0;
      linea_num   <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      error       <= 1'b0;
    end else begin
      hs_q        <= hsync;
      pix_q       <= pixel_in;
      estado      <= estado_n;
      col         <= col_n;
      linea       <= linea_n;
      pixel_out   <= pix_q;
      pixel_x     <= col_ef;
      linea_num   <= linea;
      pixel_valid <= valid_n;
      frame_start <= vs_sube;
      locked      <= locked_n;
      error       <= error_n;
    end
  end

endmodule

// File: tb/tb_receptor_vga.sv
// Directed bench for receptor_vga on a reduced 8x4 active geometry.
module tb_receptor_vga;

  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst, hsync, vsync, n_blank;
  logic [23:0] pixel_in;
  logic [23:0] pixel_out;
  logic [9:0]  pixel_x;
  logic [8:0]  linea_num;
  logic        pixel_valid, frame_start, locked, error;

  int total = 0, bad = 0;
  int err_cnt = 0, fs_cnt = 0, vld_cnt = 0, e0 = 0;
  bit hv[2];
  int hx[2], hy[2];

  receptor_vga #(.H_ACTIVO(H), .V_ACTIVO(V)) dut (
    .clk         (clk),
    .rst         (rst),
    .hsync       (hsync),
    .vsync       (vsync),
    .n_blank     (n_blank),
    .pixel_in    (pixel_in),
    .pixel_out   (pixel_out),
    .pixel_x     (pixel_x),
    .linea_num   (linea_num),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .locked      (locked),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs !== esp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  function automatic logic [23:0] pix_de(input int x, input int y);
    logic [9:0] xv;
    logic [8:0] yv;
    xv = 10'(x);
    yv = 9'(y);
    return {xv[7:0], yv[7:0], 8'hA5};
  endfunction

  // Outputs sampled now belong to the inputs driven two negedges ago.
  task automatic ciclo(input logic vs, input logic hs, input logic nb, input logic [23:0] pix,
                       input bit ev, input int x, input int y);
    @(negedge clk);
    if (hv[1]) begin
      comprobar("valid", 32'(pixel_valid), 32'd1);
      comprobar("pixel_x", 32'(pixel_x), 32'(hx[1]));
      comprobar("linea_num", 32'(linea_num), 32'(hy[1]));
      comprobar("pixel_out", 32'(pixel_out), 32'(pix_de(hx[1], hy[1])));
    end else begin
      comprobar("no_valid", 32'(pixel_valid), 32'd0);
    end
    if (error) err_cnt++;
    if (frame_start) fs_cnt++;
    if (pixel_valid) vld_cnt++;
    hv[1] = hv[0]; hx[1] = hx[0]; hy[1] = hy[0];
    hv[0] = ev;    hx[0] = x;     hy[0] = y;
    vsync = vs; hsync = hs; n_blank = nb; pixel_in = pix;
  endtask

  task automatic reset_medio();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    comprobar("rst_pixel_out", 32'(pixel_out), 32'd0);
    comprobar("rst_pixel_x", 32'(pixel_x), 32'd0);
    comprobar("rst_linea_num", 32'(linea_num), 32'd0);
    comprobar("rst_valid", 32'(pixel_valid), 32'd0);
    comprobar("rst_frame_start", 32'(frame_start), 32'd0);
    comprobar("rst_locked", 32'(locked), 32'd0);
    comprobar("rst_error", 32'(error), 32'd0);
    rst = 1'b0;
    hv[0] = 1'b0;
    hv[1] = 1'b0;
  endtask

  task automatic linea_blanco(input logic vs);
    for (int i = 0; i < 14; i++) ciclo(vs, (i == 10 || i == 11), 1'b1, '0, 1'b0, 0, 0);
  endtask

  // tipo: 0 none, 1 vsync during active, 2 hsync during active, 3 reset at ev_x
  task automatic linea_act(input int y, input int len, input bit ev, input int ev_x, input int tipo);
    for (int x = 0; x < len; x++) begin
      bit   e;
      logic vs, hs;
      if (tipo == 3 && x == ev_x) reset_medio();
      vs = (tipo == 1 && x == ev_x);
      hs = (tipo == 2 && x == ev_x);
      e  = ev && x < H && y < V && (tipo == 0 || x < ev_x);
      ciclo(vs, hs, 1'b0, pix_de(x, y), e, x, y);
    end
    for (int i = 0; i < 6; i++) ciclo(1'b0, (i == 2 || i == 3), 1'b1, '0, 1'b0, 0, 0);
  endtask

  task automatic sincro();
    linea_blanco(1'b0);
    linea_blanco(1'b1);
    linea_blanco(1'b0);
  endtask

  task automatic activos(input int n, input bit ev);
    for (int y = 0; y < n; y++) linea_act(y, H, ev, -1, 0);
  endtask

  task automatic frame_ok(input string tag);
    sincro();
    activos(V, 1'b1);
    sincro();
    comprobar(tag, 32'(locked), 32'd1);
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; hsync = 1'b0; n_blank = 1'b1; pixel_in = '0;
    hv[0] = 1'b0; hv[1] = 1'b0;
    repeat (2) @(negedge clk);
    comprobar("rst0_pixel_out", 32'(pixel_out), 32'd0);
    comprobar("rst0_pixel_x", 32'(pixel_x), 32'd0);
    comprobar("rst0_linea_num", 32'(linea_num), 32'd0);
    comprobar("rst0_valid", 32'(pixel_valid), 32'd0);
    comprobar("rst0_frame_start", 32'(frame_start), 32'd0);
    comprobar("rst0_locked", 32'(locked), 32'd0);
    comprobar("rst0_error", 32'(error), 32'd0);
    rst = 1'b0;

    // active video before any vsync is ignored
    linea_act(0, H, 1'b0, -1, 0);
    comprobar("buscar_err", err_cnt, 0);

    sincro();
    comprobar("first_vsync_locked", 32'(locked), 32'd0);
    comprobar("first_vsync_fs", fs_cnt, 1);
    vld_cnt = 0;
    activos(V, 1'b1);
    sincro();
    comprobar("f1_valid_cnt", vld_cnt, H * V);
    comprobar("f1_locked", 32'(locked), 32'd1);
    comprobar("f1_fs", fs_cnt, 2);
    vld_cnt = 0;
    activos(V, 1'b1);
    sincro();
    comprobar("f2_valid_cnt", vld_cnt, H * V);
    comprobar("f2_locked", 32'(locked), 32'd1);
    comprobar("f2_err", err_cnt, 0);

    // one line too long
    e0 = err_cnt; vld_cnt = 0;
    linea_act(0, H + 1, 1'b1, -1, 0);
    comprobar("long_err", err_cnt - e0, 1);
    comprobar("long_locked", 32'(locked), 32'd0);
    comprobar("long_valid_cnt", vld_cnt, H);
    for (int y = 1; y < V; y++) linea_act(y, H, 1'b0, -1, 0);
    comprobar("long_err_once", err_cnt - e0, 1);
    frame_ok("long_relock");

    // one line too short
    e0 = err_cnt;
    linea_act(0, H - 1, 1'b1, -1, 0);
    for (int y = 1; y < V; y++) linea_act(y, H, 1'b0, -1, 0);
    comprobar("short_err", err_cnt - e0, 1);
    comprobar("short_locked", 32'(locked), 32'd0);
    frame_ok("short_relock");

    // frame one line short
    e0 = err_cnt;
    activos(V - 1, 1'b1);
    sincro();
    comprobar("lines_err", err_cnt - e0, 1);
    comprobar("lines_locked", 32'(locked), 32'd0);
    activos(V, 1'b1);
    sincro();
    comprobar("lines_relock", 32'(locked), 32'd1);

    // vsync while active
    e0 = err_cnt; vld_cnt = 0;
    linea_act(0, H, 1'b1, 3, 1);
    for (int y = 1; y < V; y++) linea_act(y, H, 1'b0, -1, 0);
    comprobar("vs_viol_err", err_cnt - e0, 1);
    comprobar("vs_viol_valid_cnt", vld_cnt, 3);
    comprobar("vs_viol_locked", 32'(locked), 32'd0);
    frame_ok("vs_viol_relock");

    // hsync while active
    e0 = err_cnt; vld_cnt = 0;
    linea_act(0, H, 1'b1, 5, 2);
    for (int y = 1; y < V; y++) linea_act(y, H, 1'b0, -1, 0);
    comprobar("hs_viol_err", err_cnt - e0, 1);
    comprobar("hs_viol_valid_cnt", vld_cnt, 5);
    comprobar("hs_viol_locked", 32'(locked), 32'd0);
    frame_ok("hs_viol_relock");

    // reset mid-frame at line 2, pixel 5
    e0 = err_cnt;
    linea_act(0, H, 1'b1, -1, 0);
    linea_act(1, H, 1'b1, -1, 0);
    linea_act(2, H, 1'b1, 5, 3);
    linea_act(3, H, 1'b0, -1, 0);
    sincro();
    comprobar("rst_mid_locked", 32'(locked), 32'd0);
    comprobar("rst_mid_err", err_cnt - e0, 0);
    activos(V, 1'b1);
    sincro();
    comprobar("rst_mid_relock", 32'(locked), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/receptor_vga.md
RECEPTOR_VGA -- requirements
Module: receptor_vga

Interface
REQ-001 SHALL have parameter H_ACTIVO, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVO, default 480, active lines per frame.
REQ-003 SHALL have port clk, input, 1 bit; single clock, all logic rising-edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port hsync, input, 1 bit; active-high horizontal sync pulse.
REQ-006 SHALL have port vsync, input, 1 bit; active-high vertical sync pulse.
REQ-007 SHALL have port n_blank, input, 1 bit; 1 = blanking, 0 = active video.
REQ-008 SHALL have port pixel_in, input, 24 bits; R[23:16], G[15:8], B[7:0].
REQ-009 SHALL have port pixel_out, output, 24 bits; captured pixel.
REQ-010 SHALL have port pixel_x, output, 10 bits; column of pixel_out.
REQ-011 SHALL have port linea_num, output, 9 bits; line of pixel_out.
REQ-012 SHALL have port pixel_valid, output, 1 bit; pixel_out/pixel_x/linea_num valid.
REQ-013 SHALL have port frame_start, output, 1 bit; one-cycle pulse on each vsync rising edge.
REQ-014 SHALL have port locked, output, 1 bit; timing verified for the last complete frame.
REQ-015 SHALL have port error, output, 1 bit; one-cycle pulse on any timing violation.

Function
REQ-016 SHALL register all inputs in one stage; all outputs registered; pin-to-output latency exactly 2 cycles.
REQ-017 SHALL implement states BUSCAR (wait for vsync), ESPERA (vsync seen, wait for first active line), ACTIVO (capturing lines).
REQ-018 BUSCAR->ESPERA on registered vsync rising edge; ESPERA->ACTIVO on registered n_blank falling edge; ACTIVO->ESPERA on vsync rising edge.
REQ-019 Column counter SHALL clear on every n_blank falling edge and increment once per active cycle; first active pixel has pixel_x = 0.
REQ-020 Line counter SHALL clear on vsync rising edge and increment on every n_blank rising edge (end of active run) while in ACTIVO.
REQ-021 pixel_valid SHALL be 1 only when state is ACTIVO, registered n_blank = 0, column < H_ACTIVO and line < V_ACTIVO.
REQ-022 An active run ending with column count != H_ACTIVO SHALL pulse error, clear locked, and move to BUSCAR.
REQ-023 Column count reaching H_ACTIVO while still active SHALL suppress pixel_valid and saturate the counter, with no wrap-around; the error is raised at run end per REQ-022.
REQ-024 A vsync rising edge in ACTIVO with line count = V_ACTIVO SHALL set locked; any other count SHALL pulse error and clear locked.
REQ-025 n_blank = 0 while vsync = 1 (simultaneous) SHALL pulse error, clear locked, go to BUSCAR, and suppress pixel_valid.
REQ-026 hsync SHALL be monitored only; hsync = 1 during n_blank = 0 SHALL be treated as REQ-025.
REQ-027 frame_start SHALL pulse in all states, including BUSCAR.
REQ-028 error SHALL be a single-cycle pulse per violation; multiple violations in the same cycle produce one pulse.

Reset
REQ-029 On rst = 1 at a clock edge: state BUSCAR, counters 0, input register 0; pixel_out, pixel_x, linea_num, pixel_valid, frame_start, locked, error all 0 from the next cycle.
REQ-030 Reset mid-frame SHALL discard the partial frame; locked requires a fresh vsync plus one full valid frame.

Structure
REQ-031 Package vga_pkg SHALL hold H_ACTIVO/V_ACTIVO defaults, counter widths, pixel width and the state enum, shared with the transmitter controllers.
REQ-032 Sub-module detector_flanco (registered rising/falling edge detector, 1 bit) SHALL be instantiated for vsync and n_blank.

Verification
REQ-033 Two full 800x525 frames, 640x480 active, vsync on lines 490-491 -> locked = 1 after the second vsync edge; 307200 pixel_valid cycles per frame; last valid pixel has pixel_x = 639, linea_num = 479.
REQ-034 Pixel data = {x[7:0], y[7:0], 8'hA5} -> every pixel_out matches its pixel_x/linea_num, 2 cycles after input.
REQ-035 One line with 641 active cycles -> pixel_valid low on the 641st cycle, error pulses once, locked = 0, state BUSCAR.
REQ-036 Frame with 479 active lines -> error at vsync, locked = 0; next correct frame -> locked = 1.
REQ-037 rst asserted at line 200, pixel 300 -> all outputs 0 next cycle; locked regained only after a full subsequent frame.
REQ-038 n_blank = 0 with vsync = 1 -> error pulse, no pixel_valid, locked = 0.
